mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants allowed while inst_req is pending.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port rdy, input, 1: global enable; low freezes all state and outputs.
REQ-005 SHALL have port flush, input, 1: cancels a pending or in-flight instruction fetch.
REQ-006 SHALL have ports inst_req (input, 1) and inst_addr (input, 32): fetch request, level, held until done; the fetch is always 4 bytes.
REQ-007 SHALL have ports inst_rdata (output, 32) and inst_done (output, 1): fetched word and one-cycle completion pulse.
REQ-008 SHALL have ports data_req (input, 1), data_we (input, 1), data_width (input, 2), data_signed (input, 1), data_addr (input, 32) and data_wdata (input, 32): load/store request, level, held until done.
REQ-009 SHALL have ports data_rdata (output, 32) and data_done (output, 1): load result and one-cycle completion pulse, including for stores.
REQ-010 SHALL have ports mem_din (input, 8), mem_dout (output, 8), mem_a (output, 32) and mem_wr (output, 1, 1 = write): byte-serial RAM port.
REQ-011 SHALL have port busy, output, 1: high in every non-IDLE state.

Function
REQ-012 SHALL use width codes 00 = byte, 01 = half, 10 = word, giving N = 1, 2 or 4 bytes; code 11 SHALL be treated as word.
REQ-013 SHALL use states IDLE, RD_ADDR, RD_LAST, WR and DONE.
REQ-014 SHALL arbitrate only in IDLE: data_req beats inst_req, unless starve_cnt equals STARVE_LIMIT, in which case inst wins.
REQ-015 SHALL increment starve_cnt on each data grant while inst_req is high, and clear it on any inst grant or while inst_req is low.
REQ-016 SHALL latch address, width, signedness, write data and requester owner at grant; later input changes SHALL have no effect.
REQ-017 On a read, SHALL drive mem_a = addr+i in cycle i (i = 0..N-1); mem_din for byte i arrives in cycle i+1; the last byte SHALL be captured in RD_LAST.
REQ-018 SHALL assemble read bytes little-endian; for N < 4 it SHALL zero-extend, or sign-extend when data_signed is set.
REQ-019 On a write, SHALL spend N cycles in WR with mem_wr = 1, mem_a = addr+i and mem_dout = wdata[8i+7:8i].
REQ-020 SHALL drive mem_wr = 0 in every state other than WR.
REQ-021 In DONE, SHALL pulse the owner's done signal for exactly one cycle and update its rdata; the other requester's rdata SHALL hold its value. It SHALL then return to IDLE.
REQ-022 SHALL give grant-to-done latency of N+2 cycles for reads and N+1 cycles for writes, counted from the IDLE grant cycle, with rdy high throughout.
REQ-023 SHALL NOT grant the same requester in the DONE cycle; its req is re-sampled at the next IDLE.
REQ-024 On flush during an inst-owned read, SHALL go to IDLE next cycle without asserting inst_done and leave inst_rdata unchanged.
REQ-025 On flush in IDLE, SHALL suppress any inst grant in that cycle.
REQ-026 SHALL ignore flush for data-owned transactions, which always complete.
REQ-027 SHALL let the address increment wrap modulo 2^32 (0xFFFFFFFF -> 0x00000000).
REQ-028 While rdy is low, SHALL hold state, counters and all outputs; done pulses SHALL stretch until rdy is high.

Reset
REQ-029 While rst_n is low, SHALL immediately force state = IDLE, starve_cnt = 0, busy = 0, mem_wr = 0, mem_a = 0, mem_dout = 0, inst_done = 0, data_done = 0, inst_rdata = 0 and data_rdata = 0.
REQ-030 A reset mid-transaction SHALL abandon it with no done pulse; requesters re-issue.

Structure
REQ-031 SHALL take width codes, state encodings and the STARVE_LIMIT default from the shared defines package.
REQ-032 SHALL put read-byte assembly and extension in sub-module mem_byte_packer (combinational, N bytes + signed -> 32-bit); everything else stays in mem_port_arbiter.

Verification
REQ-033 Inst fetch at 0x00001000 with RAM bytes 13 12 11 10 -> inst_rdata = 0x10111213, inst_done in cycle 6, mem_wr = 0 throughout.
REQ-034 Signed byte load at 0x20 with byte 0x80 -> data_rdata = 0xFFFFFF80; the same access unsigned -> 0x00000080; each done in cycle 3.
REQ-035 Half store of 0xA1B2C3D4 at 0x7F -> 0xD4 written at 0x7F and 0xC3 at 0x80, no third write, data_done in cycle 3.
REQ-036 inst_req and data_req held continuously -> the data side gets exactly 4 grants, then inst is granted, then the pattern repeats.
REQ-037 flush in cycle 2 of a fetch -> no inst_done, busy low in cycle 3, a pending data_req is granted in cycle 3.
REQ-038 Word load at 0xFFFFFFFE -> mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; rst_n dropped mid-load -> outputs zero immediately, no data_done.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: access width codes,
// FSM state encodings and the default starvation limit.
package mem_port_arbiter_pkg;

  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_LAST = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } arb_state_t;

  // Index of the final byte of an access; code 11 behaves as a word.
  function automatic logic [1:0] last_byte_idx(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: last_byte_idx = 2'd0;
      WIDTH_HALF: last_byte_idx = 2'd1;
      default:    last_byte_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_packer.sv
// Combinational read-data packer: takes the little-endian assembled bytes
// of a 1/2/4-byte read and zero- or sign-extends it to 32 bits.
module mem_byte_packer
  import mem_port_arbiter_pkg::*;
(
  input  logic [31:0] bytes_in,
  input  logic [1:0]  width,
  input  logic        is_signed,
  output logic [31:0] word_out
);

  // Select the valid bytes and fill the upper bits with the extension bit.
  always_comb begin
    word_out = bytes_in;
    case (width)
      WIDTH_BYTE: word_out = {{24{is_signed & bytes_in[7]}}, bytes_in[7:0]};
      WIDTH_HALF: word_out = {{16{is_signed & bytes_in[15]}}, bytes_in[15:0]};
      default:    word_out = bytes_in;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one byte-serial RAM port between an instruction fetch
// requester and a load/store requester. Data normally wins, but an
// instruction fetch is forced through after STARVE_LIMIT back-to-back data
// grants. Reads spend N cycles issuing addresses plus one to catch the last
// byte (the RAM answers one cycle late); writes spend N cycles in WR.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [1:0]  data_width,
  input  logic        data_signed,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic        busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t state, state_next;

  logic [CNT_W-1:0] starve_cnt;
  logic [1:0]       idx;
  logic [1:0]       prev_idx;
  logic [1:0]       next_idx;
  logic [1:0]       width_q;
  logic [1:0]       last_idx;
  logic             owner_inst;
  logic             signed_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rbuf;
  logic [31:0]      pack_in;
  logic [31:0]      pack_out;
  logic             grant_inst;
  logic             grant_data;
  logic             flush_abort;

  assign last_idx    = last_byte_idx(width_q);
  assign prev_idx    = idx - 2'd1;
  assign next_idx    = idx + 2'd1;
  assign flush_abort = owner_inst & flush;
  assign busy        = (state != ST_IDLE);
  assign mem_wr      = (state == ST_WR);

  // Arbitration in IDLE: data first, unless the fetch side has starved long
  // enough; a flush blocks any fetch grant in that cycle.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state == ST_IDLE) begin
      if (inst_req && !flush && (!data_req || starve_cnt == STARVE_MAX)) begin
        grant_inst = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end
    end
  end

  // Next-state selection; flush only aborts fetches still reading.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (grant_inst) begin
          state_next = ST_RD_ADDR;
        end else if (grant_data) begin
          state_next = data_we ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        if (flush_abort) begin
          state_next = ST_IDLE;
        end else if (idx == last_idx) begin
          state_next = ST_RD_LAST;
        end
      end
      ST_RD_LAST: state_next = flush_abort ? ST_IDLE : ST_DONE;
      ST_WR:      if (idx == last_idx) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register, frozen while rdy is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // Starvation counter: counts data grants made while a fetch is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (rdy) begin
      if (!inst_req || grant_inst) begin
        starve_cnt <= '0;
      end else if (grant_data && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + CNT_ONE;
      end
    end
  end

  // The last read byte is taken straight from the RAM so the result is
  // ready to register on the edge into DONE.
  always_comb begin
    pack_in = rbuf;
    pack_in[{last_idx, 3'b000} +: 8] = mem_din;
  end

  mem_byte_packer u_packer (
    .bytes_in  (pack_in),
    .width     (width_q),
    .is_signed (signed_q),
    .word_out  (pack_out)
  );

  // Transaction datapath: latch the request at grant, walk the address,
  // collect read bytes, shift out write bytes and raise the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 2'd0;
      owner_inst <= 1'b0;
      width_q    <= WIDTH_BYTE;
      signed_q   <= 1'b0;
      wdata_q    <= 32'd0;
      rbuf       <= 32'd0;
      mem_a      <= 32'd0;
      mem_dout   <= 8'd0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          if (grant_inst) begin
            owner_inst <= 1'b1;
            width_q    <= WIDTH_WORD;
            signed_q   <= 1'b0;
            wdata_q    <= 32'd0;
            mem_a      <= inst_addr;
            idx        <= 2'd0;
            rbuf       <= 32'd0;
          end else if (grant_data) begin
            owner_inst <= 1'b0;
            width_q    <= data_width;
            signed_q   <= data_signed;
            wdata_q    <= data_wdata;
            mem_a      <= data_addr;
            mem_dout   <= data_wdata[7:0];
            idx        <= 2'd0;
            rbuf       <= 32'd0;
          end
        end
        ST_RD_ADDR: begin
          if (!flush_abort) begin
            if (idx != 2'd0) begin
              rbuf[{prev_idx, 3'b000} +: 8] <= mem_din;
            end
            if (idx != last_idx) begin
              idx   <= next_idx;
              mem_a <= mem_a + 32'd1;
            end
          end
        end
        ST_RD_LAST: begin
          if (!flush_abort) begin
            if (owner_inst) begin
              inst_rdata <= pack_out;
              inst_done  <= 1'b1;
            end else begin
              data_rdata <= pack_out;
              data_done  <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (idx != last_idx) begin
            idx      <= next_idx;
            mem_a    <= mem_a + 32'd1;
            mem_dout <= wdata_q[{next_idx, 3'b000} +: 8];
          end else begin
            data_done <= 1'b1;
          end
        end
        ST_DONE: begin
          inst_done <= 1'b0;
          data_done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
